clk_div_gen: RTL

CLK_DIV_GEN -- requirements
Module: clk_div_gen

---
 rtl/clk_div_gen.sv | 99 +++++++++
 1 files changed

// File: rtl/clk_div_gen.sv
// Multi-channel programmable clock divider: NCH independent counters, each with toggle or pulse output.
// Optional CLKDIV_SYNC_EN macro adds a global sync strobe for phase alignment.

module clk_div_ch #(
  parameter int CW = 27
) (
  input  logic          clk,
  input  logic          reset,
`ifdef CLKDIV_SYNC_EN
  input  logic          sync,
`endif
  input  logic          en,
  input  logic          load,
  input  logic [CW-1:0] div_val,
  input  logic          mode,
  output logic          clk_out,
  output logic          tick
);

  logic [CW-1:0] cnt, d, de_m1;
  logic          term;

  // D==0 behaves as divide-by-1, so the terminal count is 0 in that case too
  assign de_m1 = (d == '0) ? '0 : d - CW'(1);
  assign term  = (cnt == de_m1);

  // In pulse mode the output register always tracks the tick register
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt     <= '0;
      d       <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end
`ifdef CLKDIV_SYNC_EN
    else if (sync) begin
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end
`endif
    else if (load) begin
      d    <= div_val;
      cnt  <= '0;
      tick <= 1'b0;
      if (mode) clk_out <= 1'b0;
    end else if (!en) begin
      tick <= 1'b0;
      if (mode) clk_out <= 1'b0;
    end else if (term) begin
      cnt     <= '0;
      tick    <= 1'b1;
      clk_out <= mode ? 1'b1 : ~clk_out;
    end else begin
      cnt  <= cnt + CW'(1);
      tick <= 1'b0;
      if (mode) clk_out <= 1'b0;
    end
  end

endmodule

module clk_div_gen #(
  parameter int NCH = 4,
  parameter int CW  = 27
) (
  input  logic              clk,
  input  logic              reset,
`ifdef CLKDIV_SYNC_EN
  input  logic              sync,
`endif
  input  logic [NCH-1:0]    en,
  input  logic [NCH-1:0]    load,
  input  logic [NCH*CW-1:0] div_val,
  input  logic [NCH-1:0]    mode,
  output logic [NCH-1:0]    clk_out,
  output logic [NCH-1:0]    tick
);

  logic [NCH-1:0][CW-1:0] dv;
  assign dv = div_val;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    clk_div_ch #(.CW(CW)) u_ch (
      .clk     (clk),
      .reset   (reset),
`ifdef CLKDIV_SYNC_EN
      .sync    (sync),
`endif
      .en      (en[i]),
      .load    (load[i]),
      .div_val (dv[i]),
      .mode    (mode[i]),
      .clk_out (clk_out[i]),
      .tick    (tick[i])
    );
  end

endmodule
